sonar_scheduler: RTL
====================

Name: sonar_scheduler

Overview:
- Time-multiplexes the 5 ultrasonic sonar FSMs so that only one fires at a time. This removes acoustic crosstalk between sonars.
- Replaces the single global 61 ms free-running trigger/reset counter.
- Owns start and reset of every sonar FSM, captures each completed distance into a holding register, and flags fresh/timed-out results for the SPI memory map.
- Sits between the sonar FSM instances and the SPI address decoder.

Parameters:
- N_SONAR, 5, number of sonar channels scheduled.
- DIST_W, 20, distance width per channel.
- RST_CYCLES, 2, cycles the active sonar FSM is held in reset before start.
- SLOT_CYCLES, 3_050_000, max cycles from start pulse to timeout (61 ms @ 50 MHz).
- GUARD_CYCLES, 50_000, ring-down gap between slots (used only with the optional feature).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous active-low reset.
- enable_i  in  1  scheduler run enable (from SPI control word).
- mask_i  in  N_SONAR  per-sonar enable; sampled only when choosing the next slot.
- done_i  in  N_SONAR  measurement-complete level from each sonar FSM.
- dist_i  in  N_SONAR*DIST_W  raw distances from the sonar FSMs, channel i at [i*DIST_W +: DIST_W].
- rd_clr_i  in  N_SONAR  one-cycle pulse: SPI has read channel i, clear its fresh/timeout bits.
- start_o  out  N_SONAR  one-cycle start pulse to the active FSM (triggerLowStart).
- fsm_rst_o  out  N_SONAR  reset to each sonar FSM, active-high.
- dist_o  out  N_SONAR*DIST_W  held distances.
- fresh_o  out  N_SONAR  new result since last rd_clr.
- timeout_o  out  N_SONAR  last result for the channel was a timeout.
- active_o  out  3  index of the channel currently owning the slot.
- busy_o  out  1  1 whenever state != IDLE.
- round_o  out  8  completed full rounds, wraps 255->0.

Behaviour:
- Reset values:
  - start_o=0, fsm_rst_o=all 1, dist_o=0, fresh_o=0, timeout_o=0.
  - active_o=0, busy_o=0, round_o=0.
  - Internal pointer ptr=0, state IDLE.
- All outputs are registered.
- Non-active channels always have fsm_rst_o=1 and start_o=0.
- IDLE:
  - If enable_i=1 and mask_i!=0: idx = first set bit of mask_i at or after ptr, searching cyclically. Go to RST.
  - Otherwise stay in IDLE.
- RST: fsm_rst_o[idx]=1 for RST_CYCLES cycles, then START.
- START: fsm_rst_o[idx]=0 and start_o[idx]=1 for exactly 1 cycle; slot counter cleared to 0; go to WAIT.
- WAIT: counter increments each cycle.
  - If done_i[idx]=1: dist_o slice idx <= dist_i slice idx; fresh_o[idx]<=1; timeout_o[idx]<=0; go to NEXT.
  - Else if counter==SLOT_CYCLES-1: dist_o slice <= all ones (20'hFFFFF); fresh_o[idx]<=1; timeout_o[idx]<=1; go to NEXT.
  - If done and the last count coincide, done wins.
- NEXT (1 cycle):
  - fsm_rst_o[idx]<=1; ptr<=(idx+1) mod N_SONAR.
  - If the new pointer wraps past the highest enabled index, round_o increments.
  - If enable_i=0 or mask_i==0, go to IDLE; otherwise go to RST with the next enabled index.
- Latency: the start pulse comes RST_CYCLES+1 cycles after slot selection. The capture is visible 1 cycle after done_i.
- Mask or enable changes during RST/START/WAIT do not abort the current slot; they take effect at NEXT.
- A single enabled channel is re-fired back-to-back.
- done_i on non-active channels is ignored.
- rd_clr_i[i] clears fresh_o[i] and timeout_o[i]. If a capture on i happens in the same cycle, the capture wins.
- Asynchronous reset mid-slot returns all outputs to their reset values immediately.

Optional Feature:
- Macro SONAR_SCHED_GUARD_EN.
- When defined: NEXT goes to a GUARD state that holds every fsm_rst_o=1 for GUARD_CYCLES cycles before IDLE/RST selection. busy_o stays 1 during GUARD.
- When undefined: NEXT goes directly to RST/IDLE. GUARD_CYCLES is unused.

Test Plan:
- Sim parameters for all scenarios: SLOT_CYCLES=100, RST_CYCLES=2, GUARD_CYCLES=10.
- Order: enable_i=1, mask_i=5'b11111, each done_i[i] raised 20 cycles after start_o[i] with dist_i=i*100 -> start pulses in order 0,1,2,3,4,0; dist_o = 0,100,200,300,400; fresh_o=5'b11111; round_o=1 after channel 4.
- Timeout: mask_i=5'b00100, done_i never asserted -> start_o[2] every 104 cycles (2 RST + 1 START + 100 WAIT + 1 NEXT); dist_o slice 2 = 20'hFFFFF; timeout_o[2]=1.
- Mask skip and late change: mask_i=5'b10010; change mask_i to 5'b00001 while sonar 1 is in WAIT -> slots go 1, then 0; sonar 4 is never started; the slot for 1 completes normally.
- Clear vs capture: rd_clr_i[3] pulsed in the same cycle as the capture on 3 -> fresh_o[3]=1. rd_clr_i[3] one cycle later -> fresh_o[3]=0.
- Reset mid-operation: assert reset_n=0 during WAIT of sonar 2 -> within the same cycle all outputs return to reset values; after release the schedule restarts at channel 0.
- Guard (SONAR_SCHED_GUARD_EN defined): consecutive start pulses are spaced by an extra 10 cycles with all fsm_rst_o=1 during the gap.

Source files
------------

// File: rtl/sonar_scheduler.sv
// Round-robin sonar slot scheduler: fires one sonar FSM at a time, captures its distance, flags fresh/timeout.
// Optional ring-down gap between slots is enabled by defining SONAR_SCHED_GUARD_EN.
module sonar_scheduler #(
  parameter int N_SONAR      = 5,
  parameter int DIST_W       = 20,
  parameter int RST_CYCLES   = 2,
  parameter int SLOT_CYCLES  = 3_050_000,
  parameter int GUARD_CYCLES = 50_000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable_i,
  input  logic [N_SONAR-1:0]        mask_i,
  input  logic [N_SONAR-1:0]        done_i,
  input  logic [N_SONAR*DIST_W-1:0] dist_i,
  input  logic [N_SONAR-1:0]        rd_clr_i,
  output logic [N_SONAR-1:0]        start_o,
  output logic [N_SONAR-1:0]        fsm_rst_o,
  output logic [N_SONAR*DIST_W-1:0] dist_o,
  output logic [N_SONAR-1:0]        fresh_o,
  output logic [N_SONAR-1:0]        timeout_o,
  output logic [2:0]                active_o,
  output logic                      busy_o,
  output logic [7:0]                round_o,
  output logic [2:0]                state_o
);

  localparam int IDX_W  = 3;
  localparam int SLOT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
`ifdef SONAR_SCHED_GUARD_EN
  localparam int GCNT_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_NEXT  = 3'd4,
    S_GUARD = 3'd5
  } state_t;

  state_t                    state_q;
  logic [IDX_W-1:0]          idx_q;
  logic [IDX_W-1:0]          ptr_q;
  logic [RCNT_W-1:0]         rst_cnt_q;
  logic [SLOT_W-1:0]         slot_cnt_q;
  logic [7:0]                round_q;
  logic [N_SONAR-1:0]        start_q;
  logic [N_SONAR-1:0]        fsm_rst_q;
  logic [N_SONAR*DIST_W-1:0] dist_q;
  logic [N_SONAR-1:0]        fresh_q;
  logic [N_SONAR-1:0]        timeout_q;
  logic                      busy_q;
`ifdef SONAR_SCHED_GUARD_EN
  logic [GCNT_W-1:0]         guard_cnt_q;
`endif

  // First enabled channel at or after p, searching cyclically.
  function automatic logic [IDX_W-1:0] pick(input logic [N_SONAR-1:0] m,
                                            input logic [IDX_W-1:0]   p);
    logic [IDX_W-1:0] r;
    logic [IDX_W-1:0] j;
    logic             hit;
    r   = p;
    hit = 1'b0;
    for (int k = 0; k < N_SONAR; k++) begin
      j = IDX_W'((int'(p) + k) % N_SONAR);
      if (!hit && m[j]) begin
        r   = j;
        hit = 1'b1;
      end
    end
    return r;
  endfunction

  logic [IDX_W-1:0] next_ptr_d;
  logic [IDX_W-1:0] sel_ptr_d;
  logic [IDX_W-1:0] sel_next_d;
  logic             go_d;
  logic             last_en_d;

  always_comb begin
    next_ptr_d = (idx_q == IDX_W'(N_SONAR - 1)) ? '0 : idx_q + 1'b1;
    go_d       = enable_i && (|mask_i);
    sel_ptr_d  = pick(mask_i, ptr_q);
    sel_next_d = pick(mask_i, next_ptr_d);
    // A round completes when no enabled channel sits above the one just served.
    last_en_d  = 1'b1;
    for (int k = 0; k < N_SONAR; k++) begin
      if (k > int'(idx_q) && mask_i[k]) last_en_d = 1'b0;
    end
  end

  // Sonar protocol: start_o[i] is a one-cycle pulse while fsm_rst_o[i] is low; done_i[i]
  // is a level sampled only on the active channel in WAIT, so stale or foreign done is ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      ptr_q      <= '0;
      rst_cnt_q  <= '0;
      slot_cnt_q <= '0;
      round_q    <= '0;
      start_q    <= '0;
      fsm_rst_q  <= '1;
      dist_q     <= '0;
      fresh_q    <= '0;
      timeout_q  <= '0;
      busy_q     <= 1'b0;
`ifdef SONAR_SCHED_GUARD_EN
      guard_cnt_q <= '0;
`endif
    end else begin
      start_q   <= '0;
      fresh_q   <= fresh_q & ~rd_clr_i;
      timeout_q <= timeout_q & ~rd_clr_i;
      case (state_q)
        S_IDLE: begin
          if (go_d) begin
            idx_q     <= sel_ptr_d;
            rst_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_RST;
          end
        end
        S_RST: begin
          if (rst_cnt_q == RCNT_W'(RST_CYCLES - 1)) begin
            start_q[idx_q]   <= 1'b1;
            fsm_rst_q[idx_q] <= 1'b0;
            state_q          <= S_START;
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end
        S_START: begin
          slot_cnt_q <= '0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (done_i[idx_q]) begin
            dist_q[idx_q*DIST_W +: DIST_W] <= dist_i[idx_q*DIST_W +: DIST_W];
            fresh_q[idx_q]   <= 1'b1;
            timeout_q[idx_q] <= 1'b0;
            fsm_rst_q        <= '1;
            state_q          <= S_NEXT;
          end else if (slot_cnt_q == SLOT_W'(SLOT_CYCLES - 1)) begin
            dist_q[idx_q*DIST_W +: DIST_W] <= '1;
            fresh_q[idx_q]   <= 1'b1;
            timeout_q[idx_q] <= 1'b1;
            fsm_rst_q        <= '1;
            state_q          <= S_NEXT;
          end else begin
            slot_cnt_q <= slot_cnt_q + 1'b1;
          end
        end
        S_NEXT: begin
          ptr_q <= next_ptr_d;
          if (last_en_d) round_q <= round_q + 8'd1;
`ifdef SONAR_SCHED_GUARD_EN
          guard_cnt_q <= '0;
          state_q     <= S_GUARD;
`else
          if (go_d) begin
            idx_q     <= sel_next_d;
            rst_cnt_q <= '0;
            state_q   <= S_RST;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
`endif
        end
`ifdef SONAR_SCHED_GUARD_EN
        S_GUARD: begin
          // ptr_q already points past the finished channel here.
          if (guard_cnt_q == GCNT_W'(GUARD_CYCLES - 1)) begin
            if (go_d) begin
              idx_q     <= sel_ptr_d;
              rst_cnt_q <= '0;
              state_q   <= S_RST;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end else begin
            guard_cnt_q <= guard_cnt_q + 1'b1;
          end
        end
`endif
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign start_o   = start_q;
  assign fsm_rst_o = fsm_rst_q;
  assign dist_o    = dist_q;
  assign fresh_o   = fresh_q;
  assign timeout_o = timeout_q;
  assign active_o  = idx_q;
  assign busy_o    = busy_q;
  assign round_o   = round_q;
  assign state_o   = state_q;

endmodule
